// File: rtl/axi4_lite_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port between NREQ simple requesters.
// One transaction is outstanding at a time. All outputs are registered.
module axi4_lite_arbiter #(
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      REQ_VALID,
    input  logic [NREQ-1:0]      REQ_WRITE,
    input  logic [32*NREQ-1:0]   REQ_ADDR,
    input  logic [32*NREQ-1:0]   REQ_WDATA,
    output logic [NREQ-1:0]      REQ_READY,
    output logic [NREQ-1:0]      RSP_VALID,
    output logic [31:0]          RSP_RDATA,
    output logic [1:0]           RSP_RESP,
    output logic [31:0]          M_AWADDR,
    output logic                 M_AWVALID,
    input  logic                 M_AWREADY,
    output logic [31:0]          M_WDATA,
    output logic [3:0]           M_WSTRB,
    output logic                 M_WVALID,
    input  logic                 M_WREADY,
    input  logic [1:0]           M_BRESP,
    input  logic                 M_BVALID,
    output logic                 M_BREADY,
    output logic [31:0]          M_ARADDR,
    output logic                 M_ARVALID,
    input  logic                 M_ARREADY,
    input  logic [31:0]          M_RDATA,
    input  logic                 M_RVALID,
    input  logic [1:0]           M_RRESP,
    output logic                 M_RREADY
);
    localparam int GW = $clog2(NREQ);

    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R} state_t;

    state_t          state_reg;
    logic [GW-1:0]   last_grant_reg;
    logic [GW-1:0]   grant_idx;
    logic [GW-1:0]   cand;
    logic            grant_found;
    logic [31:0]     addr_reg;
    logic [31:0]     wdata_reg;
    logic [NREQ-1:0] req_ready_reg;
    logic [NREQ-1:0] rsp_valid_reg;
    logic [31:0]     rsp_rdata_reg;
    logic [1:0]      rsp_resp_reg;
    logic            awvalid_reg;
    logic            wvalid_reg;
    logic            bready_reg;
    logic            arvalid_reg;
    logic            rready_reg;

    logic [31:0] req_addr_arr  [NREQ];
    logic [31:0] req_wdata_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign req_addr_arr[gi]  = REQ_ADDR[32*gi +: 32];
            assign req_wdata_arr[gi] = REQ_WDATA[32*gi +: 32];
        end
    endgenerate

    // First requesting index after the previous winner, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = GW'((int'(last_grant_reg) + k) % NREQ);
            if (!grant_found && REQ_VALID[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            last_grant_reg <= GW'(NREQ - 1);
            addr_reg       <= '0;
            wdata_reg      <= '0;
            req_ready_reg  <= '0;
            rsp_valid_reg  <= '0;
            rsp_rdata_reg  <= '0;
            rsp_resp_reg   <= '0;
            awvalid_reg    <= 1'b0;
            wvalid_reg     <= 1'b0;
            bready_reg     <= 1'b0;
            arvalid_reg    <= 1'b0;
            rready_reg     <= 1'b0;
        end else begin
            req_ready_reg <= '0;
            rsp_valid_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        last_grant_reg           <= grant_idx;
                        addr_reg                 <= req_addr_arr[grant_idx];
                        wdata_reg                <= req_wdata_arr[grant_idx];
                        req_ready_reg[grant_idx] <= 1'b1;
                        if (REQ_WRITE[grant_idx]) begin
                            state_reg   <= WR_AW_W;
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                        end else begin
                            state_reg   <= RD_AR;
                            arvalid_reg <= 1'b1;
                        end
                    end
                end
                WR_AW_W: begin
                    if (M_AWREADY) awvalid_reg <= 1'b0;
                    if (M_WREADY)  wvalid_reg  <= 1'b0;
                    // A channel whose valid is already low has completed its handshake.
                    if ((!awvalid_reg || M_AWREADY) && (!wvalid_reg || M_WREADY)) begin
                        state_reg  <= WR_B;
                        bready_reg <= 1'b1;
                    end
                end
                WR_B: begin
                    if (M_BVALID) begin
                        bready_reg                    <= 1'b0;
                        rsp_resp_reg                  <= M_BRESP;
                        rsp_rdata_reg                 <= '0;
                        rsp_valid_reg[last_grant_reg] <= 1'b1;
                        state_reg                     <= IDLE;
                    end
                end
                RD_AR: begin
                    if (M_ARREADY) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= RD_R;
                    end
                end
                RD_R: begin
                    if (M_RVALID) begin
                        rready_reg                    <= 1'b0;
                        rsp_rdata_reg                 <= M_RDATA;
                        rsp_resp_reg                  <= M_RRESP;
                        rsp_valid_reg[last_grant_reg] <= 1'b1;
                        state_reg                     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign REQ_READY = req_ready_reg;
    assign RSP_VALID = rsp_valid_reg;
    assign RSP_RDATA = rsp_rdata_reg;
    assign RSP_RESP  = rsp_resp_reg;
    assign M_AWADDR  = addr_reg;
    assign M_AWVALID = awvalid_reg;
    assign M_WDATA   = wdata_reg;
    assign M_WSTRB   = 4'hF;
    assign M_WVALID  = wvalid_reg;
    assign M_BREADY  = bready_reg;
    assign M_ARADDR  = addr_reg;
    assign M_ARVALID = arvalid_reg;
    assign M_RREADY  = rready_reg;

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Scoreboard bench for axi4_lite_arbiter (NREQ=3) with a latency-configurable AXI4-Lite slave.
// Expected grants and responses are queued when stimulus is issued and compared as the DUT emits them.
module tb_axi4_lite_arbiter;
    localparam int NREQ = 3;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [NREQ-1:0]   REQ_VALID = '0;
    logic [NREQ-1:0]   REQ_WRITE = '0;
    logic [32*NREQ-1:0] REQ_ADDR = '0;
    logic [32*NREQ-1:0] REQ_WDATA = '0;
    logic [NREQ-1:0]   REQ_READY;
    logic [NREQ-1:0]   RSP_VALID;
    logic [31:0]       RSP_RDATA;
    logic [1:0]        RSP_RESP;
    logic [31:0]       M_AWADDR, M_WDATA, M_ARADDR;
    logic              M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY;
    logic [3:0]        M_WSTRB;
    logic              M_AWREADY = 1'b0, M_WREADY = 1'b0, M_BVALID = 1'b0;
    logic              M_ARREADY = 1'b0, M_RVALID = 1'b0;
    logic [1:0]        M_BRESP = '0, M_RRESP = '0;
    logic [31:0]       M_RDATA = '0;

    axi4_lite_arbiter #(.NREQ(NREQ)) dut (
        .clk(clk), .resetn(resetn),
        .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
        .REQ_READY(REQ_READY), .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP),
        .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RDATA(M_RDATA), .M_RVALID(M_RVALID), .M_RRESP(M_RRESP), .M_RREADY(M_RREADY)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        int          req;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } rsp_t;

    rsp_t exp_q[$];
    int   exp_grant_q[$];

    // Requester command queues, consumed by the requester agent.
    logic        cmd_wr   [NREQ][16];
    logic [31:0] cmd_addr [NREQ][16];
    logic [31:0] cmd_data [NREQ][16];
    int          cq_head  [NREQ] = '{default: 0};
    int          cq_tail  [NREQ] = '{default: 0};

    task automatic enq(input int i, input logic wr, input logic [31:0] a, input logic [31:0] d);
        cmd_wr[i][cq_tail[i]]   = wr;
        cmd_addr[i][cq_tail[i]] = a;
        cmd_data[i][cq_tail[i]] = d;
        cq_tail[i]++;
    endtask

    task automatic push_rsp(input int r, input logic [31:0] rd, input logic [1:0] rs);
        rsp_t e;
        e.req = r; e.rdata = rd; e.resp = rs;
        exp_q.push_back(e);
    endtask

    function automatic int pending_cmds();
        int s = 0;
        for (int i = 0; i < NREQ; i++) s += cq_tail[i] - cq_head[i];
        return s;
    endfunction

    // Requester agent: holds each command until its REQ_READY pulse.
    initial begin
        forever begin
            @(posedge clk); #2;
            for (int i = 0; i < NREQ; i++) begin
                if (REQ_READY[i] && cq_head[i] != cq_tail[i]) cq_head[i]++;
                if (cq_head[i] != cq_tail[i]) begin
                    REQ_VALID[i]         = 1'b1;
                    REQ_WRITE[i]         = cmd_wr[i][cq_head[i]];
                    REQ_ADDR[32*i +: 32]  = cmd_addr[i][cq_head[i]];
                    REQ_WDATA[32*i +: 32] = cmd_data[i][cq_head[i]];
                end else begin
                    REQ_VALID[i] = 1'b0;
                end
            end
        end
    end

    // Slave model; decides at the falling edge, handshakes land on the next rising edge.
    logic [31:0] slv_mem [64];
    int          aw_lat = 0, w_lat = 0, b_lat = 0, r_lat = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    int          aw_cnt, w_cnt, b_cnt, r_cnt, b_count = 0;
    int          aw_hs_cyc = -1, w_hs_cyc = -2;
    logic        aw_pend, w_pend, b_pend, ar_pend, r_pend;
    logic        aw_have, w_have, b_wait, ar_have;
    logic [31:0] aw_addr_cap, w_data_cap, ar_addr_cap;

    initial begin
        for (int k = 0; k < 64; k++) slv_mem[k] = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_ARREADY = 0; M_RVALID = 0;
                M_BRESP = 0; M_RRESP = 0; M_RDATA = 0;
                aw_pend = 0; w_pend = 0; b_pend = 0; ar_pend = 0; r_pend = 0;
                aw_have = 0; w_have = 0; b_wait = 0; ar_have = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0;
            end else begin
                if (aw_pend) begin M_AWREADY = 0; aw_have = 1; aw_hs_cyc = cyc; end
                if (w_pend)  begin M_WREADY = 0;  w_have = 1;  w_hs_cyc = cyc;  end
                if (b_pend)  begin M_BVALID = 0;  b_count++; end
                if (ar_pend) begin M_ARREADY = 0; ar_have = 1; r_cnt = 0; end
                if (r_pend)  M_RVALID = 0;
                if (M_AWVALID && !M_AWREADY) begin
                    if (aw_cnt >= aw_lat) begin M_AWREADY = 1; aw_cnt = 0; end else aw_cnt++;
                end
                if (M_WVALID && !M_WREADY) begin
                    if (w_cnt >= w_lat) begin M_WREADY = 1; w_cnt = 0; end else w_cnt++;
                end
                if (aw_have && w_have) begin
                    slv_mem[aw_addr_cap[7:2]] = w_data_cap;
                    aw_have = 0; w_have = 0; b_wait = 1; b_cnt = 0;
                end
                if (b_wait) begin
                    if (b_cnt >= b_lat) begin M_BVALID = 1; M_BRESP = bresp_cfg; b_wait = 0; end
                    else b_cnt++;
                end
                if (M_ARVALID && !M_ARREADY) M_ARREADY = 1;
                if (ar_have) begin
                    if (r_cnt >= r_lat) begin
                        M_RVALID = 1; M_RDATA = slv_mem[ar_addr_cap[7:2]]; M_RRESP = rresp_cfg;
                        ar_have = 0;
                    end else r_cnt++;
                end
                aw_pend = M_AWVALID && M_AWREADY; if (aw_pend) aw_addr_cap = M_AWADDR;
                w_pend  = M_WVALID && M_WREADY;   if (w_pend)  w_data_cap  = M_WDATA;
                b_pend  = M_BVALID && M_BREADY;
                ar_pend = M_ARVALID && M_ARREADY; if (ar_pend) ar_addr_cap = M_ARADDR;
                r_pend  = M_RVALID && M_RREADY;
            end
        end
    end

    // Monitor: pops grant and response expectations as the DUT pulses them.
    int aw_hi = 0, w_hi = 0;
    initial begin
        int   g;
        rsp_t e;
        forever begin
            @(negedge clk);
            if (M_AWVALID) aw_hi++;
            if (M_WVALID)  w_hi++;
            if (REQ_READY != '0) begin
                if (exp_grant_q.size() == 0) check("spurious_grant", REQ_READY, 0);
                else begin
                    g = exp_grant_q.pop_front();
                    check("grant", REQ_READY, 64'(1) << g);
                    $display("accept req=%0d ready=%b cycle=%0d", g, REQ_READY, cyc);
                end
            end
            if (RSP_VALID != '0) begin
                if (exp_q.size() == 0) check("spurious_rsp", RSP_VALID, 0);
                else begin
                    e = exp_q.pop_front();
                    check("rsp_valid", RSP_VALID, 64'(1) << e.req);
                    check("rsp_rdata", RSP_RDATA, e.rdata);
                    check("rsp_resp", RSP_RESP, e.resp);
                    $display("rsp req=%0d rdata=%h resp=%0d cycle=%0d", e.req, RSP_RDATA, RSP_RESP, cyc);
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || exp_grant_q.size() != 0 || pending_cmds() != 0) && n < budget) begin
            wait_cycles(1);
            n++;
        end
        check(tag, exp_q.size() + exp_grant_q.size() + pending_cmds(), 0);
        wait_cycles(2);
    endtask

    function automatic logic [63:0] reset_vec();
        return 64'({REQ_READY, RSP_VALID, RSP_RDATA, RSP_RESP,
                    M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY});
    endfunction

    initial begin
        int n, b0, rsp_cyc;
        logic found;

        // Reset state
        wait_cycles(3);
        check("reset_outputs", reset_vec(), 0);
        check("wstrb", M_WSTRB, 4'hF);
        resetn = 1'b1;
        wait_cycles(2);

        // Single write, slave ready immediately
        enq(0, 1'b1, 32'h10, 32'hDEADBEEF);
        exp_grant_q.push_back(0);
        push_rsp(0, 32'h0, 2'b00);
        wait_drain("single_write_done", 50);
        check("aw_w_same_cycle", 64'(aw_hs_cyc), 64'(w_hs_cyc));
        check("slv_reg4", slv_mem[4], 32'hDEADBEEF);

        // Skewed AW/W handshakes with a SLVERR response
        w_lat = 3; bresp_cfg = 2'b10;
        aw_hi = 0; w_hi = 0; b0 = b_count;
        enq(0, 1'b1, 32'h14, 32'hCAFE0001);
        exp_grant_q.push_back(0);
        push_rsp(0, 32'h0, 2'b10);
        wait_drain("skew_write_done", 60);
        check("awvalid_cycles", aw_hi, 1);
        check("wvalid_cycles", w_hi, 4);
        check("b_completions", b_count - b0, 1);
        check("slv_reg5", slv_mem[5], 32'hCAFE0001);
        w_lat = 0; bresp_cfg = 2'b00;

        // Read with delayed RVALID and non-OKAY response
        slv_mem[2] = 32'h12345678;
        r_lat = 5; rresp_cfg = 2'b10;
        enq(1, 1'b0, 32'h08, 32'h0);
        exp_grant_q.push_back(1);
        push_rsp(1, 32'h12345678, 2'b10);
        wait_drain("read_done", 60);
        r_lat = 0; rresp_cfg = 2'b00;

        // Fairness from reset: all requesters busy for six transactions
        resetn = 1'b0;
        wait_cycles(1);
        resetn = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                enq(i, 1'b1, 32'h80 + 32'(4 * (k * NREQ + i)), 32'h5000_0000 + 32'(k * NREQ + i));
                exp_grant_q.push_back(i);
                push_rsp(i, 32'h0, 2'b00);
            end
        end
        wait_drain("fairness_done", 200);
        check("slv_fair_last", slv_mem[32 + 5], 32'h5000_0005);

        // New request in the same cycle as a completion
        enq(0, 1'b1, 32'h30, 32'hA5A50001);
        exp_grant_q.push_back(0);
        push_rsp(0, 32'h0, 2'b00);
        n = 0;
        while (!RSP_VALID[0] && n < 50) begin wait_cycles(1); n++; end
        found = RSP_VALID[0];
        check("rsp0_seen", found, 1);
        enq(1, 1'b0, 32'h10, 32'h0);
        exp_grant_q.push_back(1);
        push_rsp(1, 32'hDEADBEEF, 2'b00);
        rsp_cyc = cyc;
        n = 0;
        while (!REQ_READY[1] && n < 10) begin wait_cycles(1); n++; end
        check("accept_gap", 64'(cyc - rsp_cyc), 1);
        check("arvalid_at_accept", M_ARVALID, 1);
        wait_drain("back_to_back_done", 60);

        // Reset while waiting for BVALID
        b_lat = 1000;
        enq(0, 1'b1, 32'h20, 32'h0BAD0BAD);
        exp_grant_q.push_back(0);
        n = 0;
        while (!M_BREADY && n < 50) begin wait_cycles(1); n++; end
        check("bready_seen", M_BREADY, 1);
        wait_cycles(2);
        resetn = 1'b0;
        wait_cycles(1);
        check("mid_reset_outputs", reset_vec(), 0);
        resetn = 1'b1;
        b_lat = 0;
        wait_cycles(5);
        enq(0, 1'b0, 32'h10, 32'h0);
        exp_grant_q.push_back(0);
        push_rsp(0, 32'hDEADBEEF, 2'b00);
        wait_drain("post_reset_read_done", 60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
